// File: rtl/m68k_bus_responder.sv
// 68000 asynchronous-bus slave bridging CPU strobes to a req/ack device port.
// Define BUS_TIMEOUT_EN to add a bus-error timeout (ERR state, berr_n).
module m68k_bus_responder #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        rw,
    input  logic [22:0] addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        dtack_n,
    output logic        berr_n,
    output logic        dev_req,
    output logic        dev_we,
    output logic [1:0]  dev_mask,
    output logic [22:0] dev_addr,
    output logic [15:0] dev_wdata,
    input  logic [15:0] dev_rdata,
    input  logic        dev_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
`ifdef BUS_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t state_q, state_d;
    logic   start;
    logic   rd_load;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q;
    logic       cnt_inc;
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        rd_load = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_inc = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!as_n && (!uds_n || !lds_n)) begin
                    state_d = REQ;
                    start   = 1'b1;
                end
            end
            // Abort outranks ack, and ack outranks the timeout.
            REQ: begin
                if (as_n) begin
                    state_d = IDLE;
                end else if (dev_ack) begin
                    state_d = ACK;
                    rd_load = !dev_we;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_inc = 1'b1;
                end
`endif
            end
            ACK: begin
                if (as_n) state_d = IDLE;
            end
`ifdef BUS_TIMEOUT_EN
            ERR: begin
                if (as_n) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cpu_din   <= '0;
            dev_we    <= 1'b0;
            dev_mask  <= '0;
            dev_addr  <= '0;
            dev_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                dev_we    <= !rw;
                dev_mask  <= {!uds_n, !lds_n};
                dev_addr  <= addr;
                dev_wdata <= cpu_dout;
            end
            if (rd_load) cpu_din <= dev_rdata;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign berr_n = (state_q != ERR);
`else
    assign berr_n = 1'b1;
`endif

    assign dev_req = (state_q == REQ);
    assign dtack_n = (state_q != ACK);

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Scoreboard bench for m68k_bus_responder: driver queues expectations,
// a negedge monitor pops them on dev_req, dtack_n and berr_n events.
module tb_m68k_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        as_n, uds_n, lds_n, rw;
    logic [22:0] addr;
    logic [15:0] cpu_dout, cpu_din;
    logic        dtack_n, berr_n;
    logic        dev_req, dev_we;
    logic [1:0]  dev_mask;
    logic [22:0] dev_addr;
    logic [15:0] dev_wdata, dev_rdata;
    logic        dev_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [22:0] addr;
        logic        we;
        logic [1:0]  mask;
        logic [15:0] wdata;
        int          len;
    } req_t;

    typedef struct {
        logic        berr;
        logic [15:0] din;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    logic [15:0] model_din = 16'h0000;

    m68k_bus_responder #(.TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .as_n      (as_n),
        .uds_n     (uds_n),
        .lds_n     (lds_n),
        .rw        (rw),
        .addr      (addr),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .dtack_n   (dtack_n),
        .berr_n    (berr_n),
        .dev_req   (dev_req),
        .dev_we    (dev_we),
        .dev_mask  (dev_mask),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s got event expected none at %0t", name, $time);
    endtask

    // Monitor
    logic prev_req = 1'b0;
    logic prev_dtack = 1'b1;
    logic prev_berr = 1'b1;
    int   req_len = 0;
    bit   have_cur = 0;
    req_t cur;

    always @(negedge clk) begin
        rsp_t s;
        if (dev_req === 1'b1 && prev_req === 1'b0) begin
            req_len = 1;
            if (req_q.size() == 0) begin
                unexpected("req_unexp");
            end else begin
                cur = req_q.pop_front();
                have_cur = 1;
                chk("req_addr", 32'(dev_addr), 32'(cur.addr));
                chk("req_we", 32'(dev_we), 32'(cur.we));
                chk("req_mask", 32'(dev_mask), 32'(cur.mask));
                if (cur.we) chk("req_wdata", 32'(dev_wdata), 32'(cur.wdata));
            end
        end else if (dev_req === 1'b1) begin
            req_len++;
        end else if (dev_req === 1'b0 && prev_req === 1'b1 && have_cur) begin
            chk("req_len", 32'(req_len), 32'(cur.len));
            have_cur = 0;
        end
        if (dtack_n === 1'b0 && prev_dtack === 1'b1) begin
            if (rsp_q.size() == 0) begin
                unexpected("dtack_unexp");
            end else begin
                s = rsp_q.pop_front();
                chk("rsp_kind_dtack", 32'(!berr_n), 32'(s.berr));
                chk("rsp_cpu_din", 32'(cpu_din), 32'(s.din));
            end
        end
        if (berr_n === 1'b0 && prev_berr === 1'b1) begin
            if (rsp_q.size() == 0) begin
                unexpected("berr_unexp");
            end else begin
                s = rsp_q.pop_front();
                chk("rsp_kind_berr", 32'(!berr_n), 32'(s.berr));
            end
        end
        prev_req   = dev_req;
        prev_dtack = dtack_n;
        prev_berr  = berr_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [22:0] a, input logic r,
                            input logic u, input logic l,
                            input logic [15:0] wd, input int len);
        req_t e;
        e.addr  = a;
        e.we    = !r;
        e.mask  = {!u, !l};
        e.wdata = wd;
        e.len   = len;
        req_q.push_back(e);
    endtask

    task automatic push_rsp(input logic b, input logic [15:0] d);
        rsp_t s;
        s.berr = b;
        s.din  = d;
        rsp_q.push_back(s);
    endtask

    task automatic drive(input logic [22:0] a, input logic r,
                         input logic u, input logic l,
                         input logic [15:0] wd);
        addr     = a;
        rw       = r;
        cpu_dout = wd;
        uds_n    = u;
        lds_n    = l;
        as_n     = 1'b0;
    endtask

    task automatic bus_idle();
        as_n    = 1'b1;
        uds_n   = 1'b1;
        lds_n   = 1'b1;
        dev_ack = 1'b0;
    endtask

    // Full transfer: pre cycles of as_n low with strobes high, then ack
    // after dly extra REQ cycles.
    task automatic xfer(input logic [22:0] a, input logic r,
                        input logic u, input logic l,
                        input logic [15:0] wd, input logic [15:0] rd,
                        input int dly, input int pre);
        push_req(a, r, u, l, wd, dly + 1);
        if (r) model_din = rd;
        push_rsp(1'b0, model_din);
        drive(a, r, 1'b1, 1'b1, wd);
        repeat (pre) begin
            step();
            chk("no_start_wo_strobe", 32'(dev_req), 32'd0);
        end
        uds_n = u;
        lds_n = l;
        step();
        chk("req_entry", 32'(dev_req), 32'd1);
        repeat (dly) step();
        dev_ack   = 1'b1;
        dev_rdata = rd;
        step();
        chk("dtack_low", 32'(dtack_n), 32'd0);
        chk("req_drop", 32'(dev_req), 32'd0);
        chk("cpu_din_hold", 32'(cpu_din), 32'(model_din));
        dev_ack   = 1'b0;
        dev_rdata = 16'hDEAD;
        bus_idle();
        step();
        chk("dtack_release", 32'(dtack_n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        rw        = 1'b1;
        addr      = '0;
        cpu_dout  = '0;
        dev_rdata = '0;
        bus_idle();
        step();
        step();
        chk("rst_dtack_n", 32'(dtack_n), 32'd1);
        chk("rst_berr_n", 32'(berr_n), 32'd1);
        chk("rst_dev_req", 32'(dev_req), 32'd0);
        chk("rst_dev_we", 32'(dev_we), 32'd0);
        chk("rst_dev_mask", 32'(dev_mask), 32'd0);
        chk("rst_dev_addr", 32'(dev_addr), 32'd0);
        chk("rst_dev_wdata", 32'(dev_wdata), 32'd0);
        chk("rst_cpu_din", 32'(cpu_din), 32'd0);
        reset = 1'b0;
        step();

        // Ack while idle is ignored
        dev_ack = 1'b1;
        step();
        step();
        chk("idle_ack_req", 32'(dev_req), 32'd0);
        chk("idle_ack_dtack", 32'(dtack_n), 32'd1);
        dev_ack = 1'b0;
        step();

        xfer(23'h000800, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 0, 0);
        xfer(23'h012345, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h7777, 3, 0);
        xfer(23'h7FFFFF, 1'b0, 1'b0, 1'b1, 16'hA5C3, 16'h0000, 1, 3);
        xfer(23'h400001, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00C1, 2, 0);
        xfer(23'h000002, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h8001, 0, 0);

        // Abort during REQ, late ack ignored
        push_req(23'h0000AA, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        drive(23'h0000AA, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        bus_idle();
        step();
        chk("abort_req", 32'(dev_req), 32'd0);
        dev_ack   = 1'b1;
        dev_rdata = 16'h5555;
        step();
        chk("abort_dtack", 32'(dtack_n), 32'd1);
        chk("abort_din", 32'(cpu_din), 32'(model_din));
        dev_ack = 1'b0;
        step();

        // Abort coinciding with ack
        push_req(23'h0000BB, 1'b1, 1'b0, 1'b0, 16'h0, 2);
        drive(23'h0000BB, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        step();
        as_n      = 1'b1;
        dev_ack   = 1'b1;
        dev_rdata = 16'h1111;
        step();
        chk("abort_ack_dtack", 32'(dtack_n), 32'd1);
        chk("abort_ack_din", 32'(cpu_din), 32'(model_din));
        bus_idle();
        step();
        step();

        // Reset while in ACK
        push_req(23'h000300, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        push_rsp(1'b0, 16'h5A5A);
        drive(23'h000300, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        dev_ack   = 1'b1;
        dev_rdata = 16'h5A5A;
        step();
        chk("pre_rst_dtack", 32'(dtack_n), 32'd0);
        reset   = 1'b1;
        dev_ack = 1'b0;
        step();
        model_din = 16'h0000;
        chk("mid_rst_dtack", 32'(dtack_n), 32'd1);
        chk("mid_rst_req", 32'(dev_req), 32'd0);
        chk("mid_rst_din", 32'(cpu_din), 32'd0);
        chk("mid_rst_addr", 32'(dev_addr), 32'd0);
        reset = 1'b0;
        bus_idle();
        step();
        xfer(23'h000800, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hCAFE, 0, 0);

`ifdef BUS_TIMEOUT_EN
        // Ack on the terminal count wins
        xfer(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0F0F, 63, 0);
        // Timeout into ERR
        push_req(23'h000020, 1'b1, 1'b0, 1'b0, 16'h0, 64);
        push_rsp(1'b1, 16'h0);
        drive(23'h000020, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        repeat (64) step();
        chk("to_berr", 32'(berr_n), 32'd0);
        chk("to_req", 32'(dev_req), 32'd0);
        step();
        chk("to_berr_hold", 32'(berr_n), 32'd0);
        bus_idle();
        step();
        chk("to_berr_release", 32'(berr_n), 32'd1);
        chk("to_dtack", 32'(dtack_n), 32'd1);
`else
        // No timeout: REQ waits until the CPU gives up
        push_req(23'h000020, 1'b1, 1'b0, 1'b0, 16'h0, 101);
        drive(23'h000020, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        repeat (100) step();
        chk("nto_req", 32'(dev_req), 32'd1);
        chk("nto_berr", 32'(berr_n), 32'd1);
        bus_idle();
        step();
        chk("nto_exit", 32'(dev_req), 32'd0);
`endif
        step();
        xfer(23'h000044, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 0);
        step();
        step();
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_bus_responder.md
M68K_BUS_RESPONDER -- requirements
Module: m68k_bus_responder

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the bus-error timeout in clk cycles (legal range 2..255).
REQ-002 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  synchronous reset, active-high.
REQ-004 as_n  in  1  CPU address strobe, active-low.
REQ-005 uds_n  in  1  upper data strobe, active-low.
REQ-006 lds_n  in  1  lower data strobe, active-low.
REQ-007 rw  in  1  CPU direction: 1 = read, 0 = write.
REQ-008 addr  in  23  CPU word address, bits [23:1].
REQ-009 cpu_dout  in  16  write data from the CPU.
REQ-010 cpu_din  out  16  read data to the CPU (registered).
REQ-011 dtack_n  out  1  data transfer acknowledge, active-low.
REQ-012 berr_n  out  1  bus error, active-low.
REQ-013 dev_req  out  1  device request, level.
REQ-014 dev_we  out  1  device write enable (= !rw latched).
REQ-015 dev_mask  out  2  byte lanes {!uds_n, !lds_n}, latched.
REQ-016 dev_addr  out  23  latched word address.
REQ-017 dev_wdata  out  16  latched write data.
REQ-018 dev_rdata  in  16  device read data, valid while dev_ack=1.
REQ-019 dev_ack  in  1  device acknowledge, one cycle or longer.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, ACK and ERR.
REQ-021 In IDLE, when as_n=0 and (uds_n=0 or lds_n=0) are sampled, the block SHALL latch addr, rw, mask and cpu_dout into dev_* and enter REQ on the next edge.
REQ-022 A write is not started until a data strobe is low, even if as_n is already low.
REQ-023 dev_req SHALL be 1 exactly while the state is REQ.
REQ-024 In REQ with dev_ack=1: a read SHALL load dev_rdata into cpu_din, and the FSM SHALL enter ACK on the same edge.
REQ-025 dtack_n SHALL be 0 exactly while the state is ACK.
REQ-026 Minimum latency is 2 edges from sampling the start condition to dtack_n=0, which occurs when dev_ack=1 in the first REQ cycle.
REQ-027 In ACK, when as_n=1 is sampled, the FSM SHALL return to IDLE, so dtack_n rises 1 cycle after as_n rises.
REQ-028 In REQ, if as_n=1 is sampled (aborted cycle), the FSM SHALL return to IDLE with no dtack_n and no cpu_din update; an abort has priority over a simultaneous dev_ack.
REQ-029 dev_ack outside REQ SHALL be ignored.
REQ-030 cpu_din SHALL hold its value until the next completed read; writes SHALL leave it unchanged.
REQ-031 Back-to-back cycles: a new start condition SHALL NOT be taken in the same cycle the FSM leaves ACK or ERR; it is taken from IDLE only.

Reset
REQ-032 On reset=1: state IDLE, dtack_n=1, berr_n=1, dev_req=0, dev_we=0, dev_mask=0, dev_addr=0, dev_wdata=0, cpu_din=0, timeout counter=0.
REQ-033 Reset asserted mid-transaction SHALL abandon it; outputs take the reset values after the next edge.

Configuration
REQ-034 Macro BUS_TIMEOUT_EN defined: an 8-bit counter SHALL clear on REQ entry and increment each REQ cycle without dev_ack.
REQ-035 With BUS_TIMEOUT_EN, when the counter reaches TIMEOUT-1 without dev_ack, the FSM SHALL enter ERR (dev_req=0); berr_n SHALL be 0 exactly while in ERR; ERR SHALL exit to IDLE when as_n=1 is sampled.
REQ-036 dev_ack on the terminal count cycle SHALL win over the timeout.
REQ-037 Macro BUS_TIMEOUT_EN undefined: no counter and no ERR state; berr_n SHALL be tied to 1; REQ waits indefinitely.

Verification
REQ-038 Read: addr=0x000800, rw=1, uds_n=lds_n=0, dev_ack=1 in the first REQ cycle, dev_rdata=0xBEEF -> dev_req high for 1 cycle, dtack_n low 2 edges after start, cpu_din=0xBEEF.
REQ-039 Byte write: cpu_dout=0x1234, uds_n=1, lds_n=0, rw=0, dev_ack 3 cycles late -> dev_mask=2'b01, dev_we=1, dev_wdata=0x1234, dev_req high for 4 cycles, cpu_din unchanged.
REQ-040 Abort: as_n rises during REQ with dev_ack=0, then dev_ack=1 one cycle later -> FSM in IDLE, dtack_n stays 1, ack ignored.
REQ-041 Timeout (BUS_TIMEOUT_EN, TIMEOUT=64): no dev_ack -> dev_req high for 64 cycles, then berr_n=0 until 1 cycle after as_n rises; without the macro, dev_req stays high and berr_n=1.
REQ-042 Reset pulse in ACK -> dtack_n=1, dev_req=0, cpu_din=0 after the next edge; the following read completes normally.
